moore_seq_det_param: RTL and testbench

- Parametrised Moore serial pattern detector, successor to the fixed 5-bit "10110" detector.
- Pattern width and value are elaboration-time parameters.
- Adds a sample-enable, a runtime overlap/non-overlap mode, and a saturating match counter with synchronous clear.
- Sits on a serial bit stream (one bit per enabled clock); its flag/count feed control logic downstream.

---
 rtl/seq_det_pkg.sv | 37 +++
 rtl/sat_counter.sv | 18 +
 rtl/moore_seq_det_param.sv | 71 +++++++
 tb/tb_moore_seq_det_param.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// Shared elaboration-time helpers for the serial pattern detectors:
// ceil-log2 sizing and the KMP-style prefix transition function.
package seq_det_pkg;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++)
      if ((32'd1 << i) < v) r = i + 1;
    return r;
  endfunction

  // Longest pattern prefix that is a suffix of (length-s prefix, then b).
  function automatic int unsigned delta(input logic [31:0] pattern,
                                        input int unsigned pat_w,
                                        input int unsigned s,
                                        input logic        b);
    int unsigned res;
    int unsigned m;
    logic        ok;
    logic        tb;
    res = 0;
    for (int unsigned k = 1; k <= pat_w; k++) begin
      if (k <= s + 1) begin
        ok = 1'b1;
        for (int unsigned i = 0; i < k; i++) begin
          m  = s + 1 - k + i;
          tb = (m < s) ? pattern[5'(pat_w - 1 - m)] : b;
          if (pattern[5'(pat_w - 1 - i)] != tb) ok = 1'b0;
        end
        if (ok) res = k;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
module sat_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                 q <= '0;
    else if (clr)             q <= '0;
    else if (inc && q != '1)  q <= q + CNT_W'(1);
  end

endmodule

// File: rtl/moore_seq_det_param.sv
// Parametrised Moore serial pattern detector with enable, runtime overlap
// mode and a saturating match counter.
module moore_seq_det_param
  import seq_det_pkg::*;
#(
  parameter int unsigned            PAT_W   = 5,
  parameter logic [PAT_W-1:0]       PATTERN = 5'b10110,
  parameter int unsigned            CNT_W   = 8,
  localparam int unsigned           SW      = clog2(PAT_W + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             j,
  input  logic             overlap,
  input  logic             clr_cnt,
  output logic             w,
  output logic [CNT_W-1:0] match_cnt,
  output logic [SW-1:0]    state
);

  localparam int unsigned NS = 2 ** SW;

  logic [SW-1:0] ps, ns, sel;
  logic [SW-1:0] tab0 [NS];
  logic [SW-1:0] tab1 [NS];
  logic          hit;

  // Transition table is fully constant; unused codes above PAT_W map to 0,
  // which also recovers any illegal state on the next enabled sample.
  for (genvar g = 0; g < NS; g++) begin : g_tab
    if (g <= PAT_W) begin : g_legal
      localparam logic [SW-1:0] D0 = SW'(delta(32'(PATTERN), PAT_W, g, 1'b0));
      localparam logic [SW-1:0] D1 = SW'(delta(32'(PATTERN), PAT_W, g, 1'b1));
      assign tab0[g] = D0;
      assign tab1[g] = D1;
    end else begin : g_illegal
      assign tab0[g] = '0;
      assign tab1[g] = '0;
    end
  end

  always_comb begin
    sel = ps;
    if (ps == SW'(PAT_W)) sel = overlap ? SW'(PAT_W) : '0;
    ns  = j ? tab1[sel] : tab0[sel];
  end

  assign hit = en && (ns == SW'(PAT_W));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ps <= '0;
      w  <= 1'b0;
    end else if (en) begin
      ps <= ns;
      w  <= (ns == SW'(PAT_W));
    end
  end

  assign state = ps;

  sat_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk (clk),
    .rst (rst),
    .inc (hit),
    .clr (clr_cnt),
    .q   (match_cnt)
  );

endmodule

// File: tb/tb_moore_seq_det_param.sv
// Scoreboard bench for moore_seq_det_param across three parameter sets.
module tb_moore_seq_det_param;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic j   = 1'b0;
  logic ov  = 1'b0;
  logic en  [3];
  logic clr [3];

  logic       w_a, w_b, w_c;
  logic [7:0] cnt_a, cnt_c;
  logic [1:0] cnt_b;
  logic [2:0] st_a, st_b;
  logic [1:0] st_c;

  always #5 clk = ~clk;

  moore_seq_det_param u_a (
    .clk(clk), .rst(rst), .en(en[0]), .j(j), .overlap(ov), .clr_cnt(clr[0]),
    .w(w_a), .match_cnt(cnt_a), .state(st_a)
  );

  moore_seq_det_param #(.CNT_W(2)) u_b (
    .clk(clk), .rst(rst), .en(en[1]), .j(j), .overlap(ov), .clr_cnt(clr[1]),
    .w(w_b), .match_cnt(cnt_b), .state(st_b)
  );

  moore_seq_det_param #(.PAT_W(3), .PATTERN(3'b111), .CNT_W(8)) u_c (
    .clk(clk), .rst(rst), .en(en[2]), .j(j), .overlap(ov), .clr_cnt(clr[2]),
    .w(w_c), .match_cnt(cnt_c), .state(st_c)
  );

  typedef struct {
    int   id;
    int   st;
    logic w;
    int   cnt;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic cmp(input string name, input int id, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s dut%0d actual=%0d required=%0d at %0t", name, id, act, req, $time);
    end
  endtask

  initial begin : monitor
    exp_t e;
    int   a_st, a_cnt;
    logic a_w;
    forever begin
      @(negedge clk);
      while (q.size() > 0) begin
        e = q.pop_front();
        case (e.id)
          0:       begin a_st = int'(st_a); a_w = w_a; a_cnt = int'(cnt_a); end
          1:       begin a_st = int'(st_b); a_w = w_b; a_cnt = int'(cnt_b); end
          default: begin a_st = int'(st_c); a_w = w_c; a_cnt = int'(cnt_c); end
        endcase
        cmp("state", e.id, a_st, e.st);
        cmp("w", e.id, int'(a_w), int'(e.w));
        cmp("match_cnt", e.id, a_cnt, e.cnt);
      end
    end
  end

  task automatic push(input int id, input int es, input logic ew, input int ec);
    exp_t e;
    e.id = id; e.st = es; e.w = ew; e.cnt = ec;
    q.push_back(e);
  endtask

  task automatic step(input int id, input logic jb, input logic e, input logic o,
                      input logic c, input int es, input logic ew, input int ec);
    @(negedge clk);
    j  = jb;
    ov = o;
    for (int i = 0; i < 3; i++) begin
      en[i]  = 1'b0;
      clr[i] = 1'b0;
    end
    en[id]  = e;
    clr[id] = c;
    @(posedge clk);
    #1;
    push(id, es, ew, ec);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b0;
    #1;
    rst = 1'b1;
  endtask

  // Feed a stream MSB-first on one DUT with per-bit expected state/count.
  task automatic run(input int id, input logic o, input logic [7:0] bits, input int n,
                     input int sts[8], input int cnts[8], input int pat_w);
    for (int i = 0; i < n; i++)
      step(id, bits[n-1-i], 1'b1, o, 1'b0, sts[i], (sts[i] == pat_w), cnts[i]);
  endtask

  initial begin : driver
    for (int i = 0; i < 3; i++) begin
      en[i]  = 1'b0;
      clr[i] = 1'b0;
    end

    // Power-on reset held for two edges.
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) push(i, 0, 1'b0, 0);
    @(negedge clk);
    rst = 1'b1;

    // Reset mid-pattern, then a full clean match.
    step(0, 1'b1, 1'b1, 1'b1, 1'b0, 1, 1'b0, 0);
    step(0, 1'b0, 1'b1, 1'b1, 1'b0, 2, 1'b0, 0);
    step(0, 1'b1, 1'b1, 1'b1, 1'b0, 3, 1'b0, 0);
    @(negedge clk);
    rst = 1'b0;
    en[0] = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    push(0, 0, 1'b0, 0);
    @(negedge clk);
    rst = 1'b1;
    run(0, 1'b1, 8'b0001_0110, 5, '{1,2,3,4,5,0,0,0}, '{0,0,0,0,1,0,0,0}, 5);

    // Overlapping detection.
    pulse_reset();
    run(0, 1'b1, 8'b1011_0110, 8, '{1,2,3,4,5,3,4,5}, '{0,0,0,0,1,1,1,2}, 5);

    // Non-overlapping detection.
    pulse_reset();
    run(0, 1'b0, 8'b1011_0110, 8, '{1,2,3,4,5,1,1,2}, '{0,0,0,0,1,1,1,1}, 5);

    // Enable gating, hold in MATCH, non-overlap exit, clear while idle.
    pulse_reset();
    step(0, 1'b1, 1'b1, 1'b0, 1'b0, 1, 1'b0, 0);
    step(0, 1'b0, 1'b1, 1'b0, 1'b0, 2, 1'b0, 0);
    step(0, 1'b1, 1'b0, 1'b0, 1'b0, 2, 1'b0, 0);
    step(0, 1'b0, 1'b0, 1'b0, 1'b0, 2, 1'b0, 0);
    step(0, 1'b1, 1'b0, 1'b0, 1'b0, 2, 1'b0, 0);
    step(0, 1'b1, 1'b1, 1'b0, 1'b0, 3, 1'b0, 0);
    step(0, 1'b1, 1'b1, 1'b0, 1'b0, 4, 1'b0, 0);
    step(0, 1'b0, 1'b1, 1'b0, 1'b0, 5, 1'b1, 1);
    step(0, 1'b1, 1'b0, 1'b0, 1'b0, 5, 1'b1, 1);
    step(0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1);
    step(0, 1'b1, 1'b0, 1'b0, 1'b1, 0, 1'b0, 0);

    // Saturation with a 2-bit counter, then clear colliding with a match.
    pulse_reset();
    run(1, 1'b1, 8'b0001_0110, 5, '{1,2,3,4,5,0,0,0}, '{0,0,0,0,1,0,0,0}, 5);
    run(1, 1'b1, 8'b0000_0110, 3, '{3,4,5,0,0,0,0,0}, '{1,1,2,0,0,0,0,0}, 5);
    run(1, 1'b1, 8'b0000_0110, 3, '{3,4,5,0,0,0,0,0}, '{2,2,3,0,0,0,0,0}, 5);
    run(1, 1'b1, 8'b0000_0110, 3, '{3,4,5,0,0,0,0,0}, '{3,3,3,0,0,0,0,0}, 5);
    step(1, 1'b1, 1'b1, 1'b1, 1'b0, 3, 1'b0, 3);
    step(1, 1'b1, 1'b1, 1'b1, 1'b0, 4, 1'b0, 3);
    step(1, 1'b0, 1'b1, 1'b1, 1'b1, 5, 1'b1, 0);

    // Short all-ones pattern, overlapping then non-overlapping.
    pulse_reset();
    run(2, 1'b1, 8'b0011_1111, 6, '{1,2,3,3,3,3,0,0}, '{0,0,1,2,3,4,0,0}, 3);
    run(2, 1'b0, 8'b0000_0111, 3, '{1,2,3,0,0,0,0,0}, '{4,4,5,0,0,0,0,0}, 3);

    // Drain the scoreboard with a bounded wait.
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d required=0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
